// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one ALU between NUM_REQ requesters. Requests are granted
//   round-robin, one at a time. The winner's operands and opcode are driven
//   to the ALU and held, the ALU result is captured after ALU_LATENCY clocks,
//   and it is returned on a single response channel tagged with the requester
//   id. Only one operation is in flight at a time (IDLE -> EXEC -> RESP).
//
// Optional feature macro: ALU_OPCODE_CHECK_EN
//   When defined, a granted op with opcode > 4'b1010, or opcode 4'b0011 with
//   b == 0, bypasses the ALU: it goes straight to RESP with rsp_err=1 and
//   rsp_result=0, and the ALU inputs keep their previous values.
//   When undefined, every op goes through the ALU and rsp_err is tied to 0.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a/b/op        packed operands (16 bits each) and opcode (4 bits)
//   alu_a/b/op        operands/opcode to the ALU
//   alu_result        result from the ALU
//   rsp_valid/ready   response handshake
//   rsp_id            requester index of the response
//   rsp_result        captured ALU result
//   rsp_err           rejected-op flag (see macro above)
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ALU_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*16-1:0]   req_a,
  input  logic [NUM_REQ*16-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic [15:0]             alu_a,
  output logic [15:0]             alu_b,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_err
);

  localparam int CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]  exec_cnt_reg, exec_cnt_next;
  logic [15:0]       alu_a_reg, alu_a_next;
  logic [15:0]       alu_b_reg, alu_b_next;
  logic [3:0]        alu_op_reg, alu_op_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
  logic [31:0]       rsp_result_reg, rsp_result_next;

  // Unpacked per-requester views of the packed operand buses.
  logic [15:0] req_a_arr  [NUM_REQ];
  logic [15:0] req_b_arr  [NUM_REQ];
  logic [3:0]  req_op_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi]  = req_a[16*gi +: 16];
      assign req_b_arr[gi]  = req_b[16*gi +: 16];
      assign req_op_arr[gi] = req_op[4*gi +: 4];
    end
  endgenerate

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  logic            grant_found;
  logic [ID_W-1:0] winner;

  always_comb begin
    grant_found = 1'b0;
    winner      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        winner      = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  logic [15:0]     sel_a, sel_b;
  logic [3:0]      sel_op;
  logic [ID_W-1:0] ptr_after;

  assign sel_a     = req_a_arr[winner];
  assign sel_b     = req_b_arr[winner];
  assign sel_op    = req_op_arr[winner];
  assign ptr_after = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

`ifdef ALU_OPCODE_CHECK_EN
  logic rsp_err_reg, rsp_err_next;
  logic op_illegal;
  assign op_illegal = (sel_op > 4'hA) || ((sel_op == 4'h3) && (sel_b == 16'h0));
  assign rsp_err    = rsp_err_reg;
`else
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      exec_cnt_reg   <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
`ifdef ALU_OPCODE_CHECK_EN
      rsp_err_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      exec_cnt_reg   <= exec_cnt_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      alu_op_reg     <= alu_op_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_result_reg <= rsp_result_next;
`ifdef ALU_OPCODE_CHECK_EN
      rsp_err_reg    <= rsp_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    exec_cnt_next   = exec_cnt_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    alu_op_next     = alu_op_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_result_next = rsp_result_reg;
    req_ready       = '0;
`ifdef ALU_OPCODE_CHECK_EN
    rsp_err_next    = rsp_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          // Ready is driven only for a valid winner, so the handshake
          // completes in this cycle.
          req_ready[winner] = 1'b1;
          rsp_id_next       = winner;
          rr_ptr_next       = ptr_after;
`ifdef ALU_OPCODE_CHECK_EN
          if (op_illegal) begin
            rsp_err_next    = 1'b1;
            rsp_result_next = '0;
            rsp_valid_next  = 1'b1;
            state_next      = RESP;
          end else begin
            rsp_err_next    = 1'b0;
            alu_a_next      = sel_a;
            alu_b_next      = sel_b;
            alu_op_next     = sel_op;
            exec_cnt_next   = CNT_W'(ALU_LATENCY);
            state_next      = EXEC;
          end
`else
          alu_a_next    = sel_a;
          alu_b_next    = sel_b;
          alu_op_next   = sel_op;
          exec_cnt_next = CNT_W'(ALU_LATENCY);
          state_next    = EXEC;
`endif
        end
      end
      EXEC: begin
        exec_cnt_next = exec_cnt_reg - 1'b1;
        // Last counted cycle: the ALU output now reflects the held inputs.
        if (exec_cnt_reg == CNT_W'(1)) begin
          rsp_result_next = alu_result;
          rsp_valid_next  = 1'b1;
          state_next      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign alu_op     = alu_op_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Self-checking bench for alu_rr_scheduler. A combinational behavioural ALU
//   answers the DUT's ALU port. A transaction-level model keeps each
//   requester's pending op and the round-robin pointer, predicts the winner,
//   the response latency, and the returned id/result/error.
//   Honours ALU_OPCODE_CHECK_EN when the same macro is defined for the bench.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a, req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [15:0]           alu_a, alu_b;
  logic [3:0]            alu_op;
  logic [31:0]           alu_result;
  logic                  rsp_valid, rsp_ready, rsp_err;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic        pend_v  [NUM_REQ];
  logic [15:0] pend_a  [NUM_REQ];
  logic [15:0] pend_b  [NUM_REQ];
  logic [3:0]  pend_op [NUM_REQ];
  int          model_ptr;
  logic [15:0] last_a, last_b;
  logic [3:0]  last_op;
  int          obs_id;
  logic [31:0] obs_result;
  logic        obs_err;

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op);
    logic [31:0] wa, wb;
    wa = {16'h0, a};
    wb = {16'h0, b};
    case (op)
      4'h0: return wa + wb;
      4'h1: return wa - wb;
      4'h2: return wa * wb;
      4'h3: return (b == 16'h0) ? 32'h0 : wa / wb;
      4'h4: return wa & wb;
      4'h5: return wa | wb;
      4'h6: return wa ^ wb;
      4'h7: return wa << b[3:0];
      4'h8: return wa >> b[3:0];
      4'h9: return wa + 32'd1;
      4'hA: return wa - 32'd1;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);

  function automatic bit op_rejected(input logic [3:0] op, input logic [15:0] b);
`ifdef ALU_OPCODE_CHECK_EN
    return (op > 4'hA) || (op == 4'h3 && b == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_winner();
    for (int k = 0; k < NUM_REQ; k++)
      if (pend_v[(model_ptr + k) % NUM_REQ]) return (model_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = pend_v[i];
      req_a[16*i +: 16]  = pend_a[i];
      req_b[16*i +: 16]  = pend_b[i];
      req_op[4*i +: 4]   = pend_op[i];
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op);
    pend_v[i] = 1'b1; pend_a[i] = a; pend_b[i] = b; pend_op[i] = op;
  endtask

  task automatic rand_op(input int i);
    logic [15:0] b;
    b = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
    set_op(i, 16'($urandom), b, 4'($urandom_range(0, 15)));
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_all();
    drive_reqs();
    rsp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 0;
    last_a = '0; last_b = '0; last_op = '0;
    #1;
  endtask

  // One full transaction from the IDLE state; called at negedge+1.
  task automatic run_op(input string tag, input bit refill, input int stall);
    int w, lat;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [31:0] exp_res;
    logic exp_err;
    drive_reqs();
    #1;
    w = model_winner();
    if (w < 0) begin
      failures++;
      $display("FAIL %s setup: no pending request, got none expected one", tag);
      return;
    end
    exp_rdy = '0;
    exp_rdy[w] = 1'b1;
    checks++;
    if (req_ready !== exp_rdy) begin
      failures++;
      $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, exp_rdy);
    end
    exp_err = op_rejected(pend_op[w], pend_b[w]);
    exp_res = exp_err ? 32'h0 : alu_f(pend_a[w], pend_b[w], pend_op[w]);
    if (!exp_err) begin
      last_a = pend_a[w]; last_b = pend_b[w]; last_op = pend_op[w];
    end
    lat = exp_err ? 1 : LAT + 1;
    model_ptr = (w + 1) % NUM_REQ;
    @(posedge clk);
    if (refill) rand_op(w); else pend_v[w] = 1'b0;
    @(negedge clk);
    drive_reqs();
    #1;
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      checks++;
      if (rsp_valid !== (k == lat) || req_ready !== '0 ||
          alu_a !== last_a || alu_b !== last_b || alu_op !== last_op) begin
        failures++;
        $display("FAIL %s latency k=%0d: rsp_valid=%b req_ready=%b alu=%h/%h/%h expected valid=%b ready=0 alu=%h/%h/%h",
                 tag, k, rsp_valid, req_ready, alu_a, alu_b, alu_op,
                 (k == lat), last_a, last_b, last_op);
      end
    end
    obs_id = int'(rsp_id); obs_result = rsp_result; obs_err = rsp_err;
    checks++;
    if (rsp_id !== ID_W'(w) || rsp_result !== exp_res || rsp_err !== exp_err) begin
      failures++;
      $display("FAIL %s response: id=%0d result=%0d err=%b expected id=%0d result=%0d err=%b",
               tag, rsp_id, rsp_result, rsp_err, w, exp_res, exp_err);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(w) || rsp_result !== exp_res ||
          req_ready !== '0 || alu_a !== last_a || alu_op !== last_op) begin
        failures++;
        $display("FAIL %s stall %0d: valid=%b id=%0d result=%0d ready=%b expected 1/%0d/%0d/0",
                 tag, s, rsp_valid, rsp_id, rsp_result, req_ready, w, exp_res);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s release: rsp_valid=%b expected 0", tag, rsp_valid);
    end
    $display("op %s: id=%0d result=%0d err=%b", tag, obs_id, obs_result, obs_err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rsp_ready = 1'b0;
    clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin pend_a[i] = '0; pend_b[i] = '0; pend_op[i] = '0; end
    drive_reqs();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_id, rsp_result, alu_a, alu_b, alu_op, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_state: outputs valid=%b id=%0d result=%0d alu=%h/%h/%h expected all 0",
               rsp_valid, rsp_id, rsp_result, alu_a, alu_b, alu_op);
    end
    reset = 1'b0;
    model_ptr = 0;
    last_a = '0; last_b = '0; last_op = '0;
    // Start an op on requester 2, then reset while it executes.
    @(negedge clk);
    set_op(2, 16'd100, 16'd3, 4'h0);
    drive_reqs();
    @(posedge clk);
    @(negedge clk);
    pend_v[2] = 1'b0;
    drive_reqs();
    #1;
    checks++;
    if (alu_a !== 16'd100 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_exec: alu_a=%0d rsp_valid=%b expected 100/0", alu_a, rsp_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_id, rsp_result, alu_a, alu_b, alu_op, req_ready} !== '0) begin
      failures++;
      $display("FAIL reset_async: valid=%b id=%0d result=%0d alu=%h/%h/%h expected all 0",
               rsp_valid, rsp_id, rsp_result, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_rsp: rsp_valid=%b expected 0", rsp_valid);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) rand_op(i);
    run_op("reset_next", 1'b0, 0);
    checks++;
    if (obs_id !== 0) begin
      failures++;
      $display("FAIL reset_next_id: id=%0d expected 0", obs_id);
    end
    clear_all();
  endtask

  task automatic test_single_op();
    set_op(1, 16'd10, 16'd5, 4'h0);
    run_op("single", 1'b0, 0);
    checks++;
    if (obs_id !== 1 || obs_result !== 32'd15) begin
      failures++;
      $display("FAIL single_value: id=%0d result=%0d expected 1/15", obs_id, obs_result);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) rand_op(i);
    for (int n = 0; n < 5; n++) begin
      run_op("rr", 1'b1, 0);
      checks++;
      if (obs_id !== order[n]) begin
        failures++;
        $display("FAIL rr_order n=%0d: id=%0d expected %0d", n, obs_id, order[n]);
      end
    end
    clear_all();
  endtask

  task automatic test_backpressure();
    set_op(0, 16'd7, 16'd9, 4'h2);
    set_op(3, 16'd300, 16'd2, 4'h1);
    run_op("bp_stall", 1'b0, 10);
    run_op("bp_next", 1'b0, 0);
    clear_all();
  endtask

  task automatic test_single_requester();
    set_op(3, 16'd1, 16'd2, 4'h0);
    for (int n = 0; n < 5; n++) begin
      run_op("single_req", 1'b1, n % 2);
      checks++;
      if (obs_id !== 3) begin
        failures++;
        $display("FAIL single_req_id n=%0d: id=%0d expected 3", n, obs_id);
      end
    end
    clear_all();
  endtask

  task automatic test_mixed_ops();
    set_op(2, 16'd134, 16'd8, 4'h7);
    run_op("mix_shl", 1'b0, 1);
    checks++;
    if (obs_result !== 32'd34304) begin
      failures++;
      $display("FAIL mix_shl_value: result=%0d expected 34304", obs_result);
    end
    set_op(3, 16'd27, 16'd4, 4'hA);
    run_op("mix_dec", 1'b0, 0);
    checks++;
    if (obs_result !== 32'd26) begin
      failures++;
      $display("FAIL mix_dec_value: result=%0d expected 26", obs_result);
    end
    set_op(0, 16'd15, 16'd10, 4'h4);
    run_op("mix_and", 1'b0, 2);
    checks++;
    if (obs_result !== 32'd10) begin
      failures++;
      $display("FAIL mix_and_value: result=%0d expected 10", obs_result);
    end
  endtask

  task automatic test_opcode_check();
    set_op(1, 16'd5, 16'd5, 4'hF);
    run_op("opc_ff", 1'b0, 0);
`ifdef ALU_OPCODE_CHECK_EN
    checks++;
    if (obs_err !== 1'b1 || obs_result !== 32'h0) begin
      failures++;
      $display("FAIL opc_ff_err: err=%b result=%0d expected 1/0", obs_err, obs_result);
    end
    set_op(2, 16'd25, 16'd0, 4'h3);
    run_op("opc_div0", 1'b0, 0);
    checks++;
    if (obs_err !== 1'b1) begin
      failures++;
      $display("FAIL opc_div0_err: err=%b expected 1", obs_err);
    end
`else
    checks++;
    if (obs_err !== 1'b0 || obs_result !== 32'h0) begin
      failures++;
      $display("FAIL opc_ff_pass: err=%b result=%0d expected 0/0", obs_err, obs_result);
    end
`endif
    set_op(3, 16'd25, 16'd5, 4'h3);
    run_op("opc_div", 1'b0, 0);
    checks++;
    if (obs_err !== 1'b0 || obs_result !== 32'd5) begin
      failures++;
      $display("FAIL opc_div_value: err=%b result=%0d expected 0/5", obs_err, obs_result);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend_v[i] && $urandom_range(0, 1) == 1) rand_op(i);
        else if (pend_v[i] && $urandom_range(0, 7) == 0) pend_v[i] = 1'b0;
      end
      if (model_winner() < 0) rand_op(int'($urandom_range(0, NUM_REQ - 1)));
      run_op("random", 1'b0, int'($urandom_range(0, 3)));
    end
    clear_all();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_single_requester();
    test_mixed_ops();
    test_opcode_check();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
